// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues requests to a variable-latency
// instruction memory, selects the next PC by redirect priority, and presents
// one instruction (or a NOP bubble) to the IF/ID register every cycle.
module if_fetch_stage #(
  parameter logic [31:0] RESET_VECTOR = 32'h80000000,
  parameter logic [31:0] IRQ_VECTOR   = 32'h80000004,
  parameter logic [31:0] EXC_VECTOR   = 32'h80000008,
  parameter logic [31:0] NOP_INSTR    = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        exception,
  input  logic        irq,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruction_next,
  output logic [31:0] PC_next,
  output logic        if_valid,
  output logic        if_flush
);

  // FETCH: request outstanding at fetch_pc.
  // HOLD : word returned during a stall, parked in the buffer.
  // DROP : redirect arrived mid-request; wait out the stale response.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] fetch_pc_reg, fetch_pc_next;
  logic [31:0] buf_instr_reg, buf_instr_next;
  logic [31:0] drop_target_reg, drop_target_next;

  logic [31:0] seq_pc;
  logic        irq_ok;
  logic        redirect;
  logic [31:0] redirect_target;

  // Sequential PC keeps the kernel flag in bit 31; only the low 31 bits wrap.
  assign seq_pc = {fetch_pc_reg[31], fetch_pc_reg[30:0] + 31'd4};

  // Interrupts are masked while executing in kernel space.
  assign irq_ok = irq & ~fetch_pc_reg[31];

  // Redirect arbitration: exception > irq > branch > jump.
  always_comb begin
    redirect        = 1'b1;
    redirect_target = EXC_VECTOR;
    if (exception) begin
      redirect_target = EXC_VECTOR;
    end else if (irq_ok) begin
      redirect_target = IRQ_VECTOR;
    end else if (branch_taken) begin
      redirect_target = branch_target;
    end else if (jump) begin
      redirect_target = jump_target;
    end else begin
      redirect = 1'b0;
    end
  end

  // Next-state, next-PC and IF/ID-facing outputs.
  always_comb begin
    state_next       = state_reg;
    fetch_pc_next    = fetch_pc_reg;
    buf_instr_next   = buf_instr_reg;
    drop_target_next = drop_target_reg;
    imem_req         = 1'b0;
    imem_addr        = fetch_pc_reg;
    Instruction_next = NOP_INSTR;
    PC_next          = 32'h0;
    if_valid         = 1'b0;
    if_flush         = 1'b0;

    if (!reset) begin
      // Quiet outputs while reset is held; register values are don't-care.
      imem_addr = RESET_VECTOR;
    end else begin
      case (state_reg)
        FETCH: begin
          imem_req = 1'b1;
          if_flush = redirect;
          if (redirect) begin
            if (imem_ready) begin
              // Response arrives with the redirect: drop it and restart.
              fetch_pc_next = redirect_target;
            end else begin
              drop_target_next = redirect_target;
              state_next       = DROP;
            end
          end else if (imem_ready) begin
            Instruction_next = imem_rdata;
            PC_next          = seq_pc;
            if_valid         = 1'b1;
            if (!stall) begin
              fetch_pc_next = seq_pc;
            end else begin
              // ID cannot take it; park the word until the stall clears.
              buf_instr_next = imem_rdata;
              state_next     = HOLD;
            end
          end
        end

        HOLD: begin
          if_flush = redirect;
          if (redirect) begin
            fetch_pc_next = redirect_target;
            state_next    = FETCH;
          end else begin
            Instruction_next = buf_instr_reg;
            PC_next          = seq_pc;
            if_valid         = 1'b1;
            if (!stall) begin
              fetch_pc_next = seq_pc;
              state_next    = FETCH;
            end
          end
        end

        DROP: begin
          // Keep the old request stable until memory answers it.
          imem_req = 1'b1;
          if_flush = redirect;
          if (redirect) begin
            drop_target_next = redirect_target;
          end
          if (imem_ready) begin
            fetch_pc_next = redirect ? redirect_target : drop_target_reg;
            state_next    = FETCH;
          end
        end

        default: begin
          state_next = FETCH;
        end
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg       <= FETCH;
      fetch_pc_reg    <= RESET_VECTOR;
      buf_instr_reg   <= NOP_INSTR;
      drop_target_reg <= RESET_VECTOR;
    end else begin
      state_reg       <= state_next;
      fetch_pc_reg    <= fetch_pc_next;
      buf_instr_reg   <= buf_instr_next;
      drop_target_reg <= drop_target_next;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage. Stimulus pushes the expected
// {instruction, PC_next} of every word ID will consume; a monitor pops and
// compares whenever a word is actually consumed (if_valid & ~stall).
module tb_if_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        exception;
  logic        irq;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] Instruction_next;
  logic [31:0] PC_next;
  logic        if_valid;
  logic        if_flush;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcn;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  if_fetch_stage dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .exception        (exception),
    .irq              (irq),
    .branch_taken     (branch_taken),
    .branch_target    (branch_target),
    .jump             (jump),
    .jump_target      (jump_target),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_ready       (imem_ready),
    .imem_rdata       (imem_rdata),
    .Instruction_next (Instruction_next),
    .PC_next          (PC_next),
    .if_valid         (if_valid),
    .if_flush         (if_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: a distinct word per address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h0BAD_F00D;
  endfunction

  assign imem_rdata = imem_ready ? mem_word(imem_addr) : 32'hDEAD_BEEF;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] pcn);
    exp_t e;
    e.instr = mem_word(a);
    e.pcn   = pcn;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every word ID consumes against the scoreboard.
  always @(negedge clk) begin
    if (reset === 1'b1 && if_valid === 1'b1 && stall === 1'b0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", PC_next, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("instr", Instruction_next, e.instr);
        chk("pc_next", PC_next, e.pcn);
        $display("consumed instr=%h pc_next=%h", Instruction_next, PC_next);
      end
    end
  end

  initial begin
    reset = 1'b0; stall = 1'b0; exception = 1'b0; irq = 1'b0;
    branch_taken = 1'b0; branch_target = 32'h0; jump = 1'b0; jump_target = 32'h0;
    imem_ready = 1'b0;

    // Reset held for three cycles.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_req", {31'h0, imem_req}, 32'h0);
      chk("rst_valid", {31'h0, if_valid}, 32'h0);
      chk("rst_addr", imem_addr, 32'h80000000);
      tick();
    end
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_req", {31'h0, imem_req}, 32'h1);
    chk("post_rst_addr", imem_addr, 32'h80000000);

    // Jump to 0 coincident with ready: response dropped.
    tick(); jump = 1'b1; jump_target = 32'h0; imem_ready = 1'b1;
    @(negedge clk);
    chk("jmp_flush", {31'h0, if_flush}, 32'h1);
    chk("jmp_valid", {31'h0, if_valid}, 32'h0);

    // Zero-wait stream 0,4 then stall at 8.
    tick(); jump = 1'b0; push(32'h0, 32'h4);
    @(negedge clk); chk("addr0", imem_addr, 32'h0);
    tick(); push(32'h4, 32'h8);
    @(negedge clk); chk("addr4", imem_addr, 32'h4);
    tick(); stall = 1'b1; push(32'h8, 32'hC);
    @(negedge clk); chk("addr8", imem_addr, 32'h8);
    for (int i = 0; i < 2; i++) begin
      tick(); imem_ready = 1'b0;
      @(negedge clk);
      chk("hold_req", {31'h0, imem_req}, 32'h0);
      chk("hold_instr", Instruction_next, mem_word(32'h8));
      chk("hold_pcn", PC_next, 32'hC);
    end
    tick(); stall = 1'b0;
    @(negedge clk); chk("hold_release_req", {31'h0, imem_req}, 32'h0);
    tick(); imem_ready = 1'b1; push(32'hC, 32'h10);
    @(negedge clk); chk("addrC", imem_addr, 32'hC);

    // Branch while waiting at 10.
    tick(); imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h40;
    @(negedge clk);
    chk("br_flush", {31'h0, if_flush}, 32'h1);
    chk("br_addr", imem_addr, 32'h10);
    chk("br_valid", {31'h0, if_valid}, 32'h0);
    tick(); branch_taken = 1'b0;
    @(negedge clk);
    chk("drop_addr", imem_addr, 32'h10);
    chk("drop_req", {31'h0, imem_req}, 32'h1);
    chk("drop_flush", {31'h0, if_flush}, 32'h0);
    tick(); imem_ready = 1'b1;
    @(negedge clk);
    chk("drop_ready_addr", imem_addr, 32'h10);
    chk("drop_ready_valid", {31'h0, if_valid}, 32'h0);
    tick(); imem_ready = 1'b0;
    @(negedge clk);
    chk("br_target_addr", imem_addr, 32'h40);
    chk("br_target_req", {31'h0, imem_req}, 32'h1);

    // Priority at pc=100.
    tick(); jump = 1'b1; jump_target = 32'h100; imem_ready = 1'b1;
    @(negedge clk); chk("j100_flush", {31'h0, if_flush}, 32'h1);
    tick(); jump = 1'b0; exception = 1'b1; irq = 1'b1; branch_taken = 1'b1;
    @(negedge clk);
    chk("addr100", imem_addr, 32'h100);
    chk("prio_flush", {31'h0, if_flush}, 32'h1);
    tick(); exception = 1'b0; irq = 1'b0; branch_taken = 1'b0;
    jump = 1'b1; jump_target = 32'h80000020;
    @(negedge clk); chk("exc_vector", imem_addr, 32'h80000008);

    // IRQ ignored in kernel space.
    tick(); jump = 1'b0; irq = 1'b1; push(32'h80000020, 32'h80000024);
    @(negedge clk);
    chk("addr80000020", imem_addr, 32'h80000020);
    chk("irq_masked_flush", {31'h0, if_flush}, 32'h0);
    tick(); irq = 1'b0; jump = 1'b1; jump_target = 32'h7FFFFFFC;
    @(negedge clk); chk("addr80000024", imem_addr, 32'h80000024);

    // Wrap without carrying into bit 31.
    tick(); jump = 1'b0; push(32'h7FFFFFFC, 32'h0);
    @(negedge clk); chk("addr7FFFFFFC", imem_addr, 32'h7FFFFFFC);
    tick(); jump = 1'b1; jump_target = 32'hFFFFFFFC;
    @(negedge clk); chk("wrap_user", imem_addr, 32'h0);
    tick(); jump = 1'b0; push(32'hFFFFFFFC, 32'h80000000);
    @(negedge clk); chk("addrFFFFFFFC", imem_addr, 32'hFFFFFFFC);

    // Chained redirects while dropping: latest wins.
    tick(); imem_ready = 1'b0; jump = 1'b1; jump_target = 32'h200;
    @(negedge clk);
    chk("wrap_kernel", imem_addr, 32'h80000000);
    chk("chain_flush1", {31'h0, if_flush}, 32'h1);
    tick(); jump = 1'b0; branch_taken = 1'b1; branch_target = 32'h300;
    @(negedge clk);
    chk("chain_flush2", {31'h0, if_flush}, 32'h1);
    chk("chain_hold_addr", imem_addr, 32'h80000000);
    tick(); branch_taken = 1'b0; imem_ready = 1'b1;
    @(negedge clk); chk("chain_valid", {31'h0, if_valid}, 32'h0);
    tick(); imem_ready = 1'b0;
    @(negedge clk); chk("chain_target", imem_addr, 32'h300);

    tick();
    @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
